// File: rtl/factorial_engine_if.sv
// Request/result handshake bundle for factorial_engine.
// The master drives requests and accepts results; the slave is the engine.
interface factorial_engine_if #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 46
) ();

  logic [IN_W-1:0]  in_data;
  logic             in_mode;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;
  logic             out_busy;

  modport master (
    output in_data, in_mode, in_valid, out_ready,
    input  in_ready, out_data, out_ovf, out_valid, out_busy
  );

  modport slave (
    input  in_data, in_mode, in_valid, out_ready,
    output in_ready, out_data, out_ovf, out_valid, out_busy
  );

endinterface

// File: rtl/factorial_engine.sv
// Iterative n! / n!! engine, one multiply per cycle, valid/ready on both sides.
// Optional overflow saturation is enabled with the macro FACTORIAL_ENGINE_OVF_EN.
module factorial_engine #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 46
) (
  input logic               clk,
  input logic               resetn,
  factorial_engine_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [IN_W-1:0]  cnt_q, cnt_d;
  logic             step2_q, step2_d;
  logic             valid_q, valid_d;
  logic [OUT_W+IN_W-1:0] prod;

  // Full-width product so that the bits above OUT_W reveal overflow.
  assign prod = {{IN_W{1'b0}}, acc_q} * {{OUT_W{1'b0}}, cnt_q};

`ifdef FACTORIAL_ENGINE_OVF_EN
  logic ovf_q, ovf_d;
  logic prod_ovf;
  assign prod_ovf    = |prod[OUT_W+IN_W-1:OUT_W];
  assign bus.out_ovf = ovf_q;
`else
  // Without detection the result simply wraps modulo 2^OUT_W.
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod[OUT_W+IN_W-1:OUT_W];
  assign bus.out_ovf    = 1'b0;
`endif

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_busy  = (state_q != StIdle);
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;

  // Next-state and datapath updates for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    step2_d = step2_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef FACTORIAL_ENGINE_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          cnt_d   = bus.in_data;
          step2_d = bus.in_mode;
          acc_d   = OUT_W'(1);
`ifdef FACTORIAL_ENGINE_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (cnt_q <= IN_W'(1)) begin
          data_d  = acc_q;
          valid_d = 1'b1;
          state_d = StDone;
`ifdef FACTORIAL_ENGINE_OVF_EN
        end else if (prod_ovf) begin
          data_d  = '1;
          ovf_d   = 1'b1;
          valid_d = 1'b1;
          state_d = StDone;
`endif
        end else begin
          acc_d = prod[OUT_W-1:0];
          // cnt >= 2 here, so subtracting the step never wraps.
          cnt_d = cnt_q - (step2_q ? IN_W'(2) : IN_W'(1));
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      acc_q   <= OUT_W'(1);
      cnt_q   <= '0;
      step2_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef FACTORIAL_ENGINE_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      step2_q <= step2_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef FACTORIAL_ENGINE_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_factorial_engine.sv
// Directed bench for factorial_engine: a default-width instance and a 16-bit
// result instance, with expected results queued at accept and checked on output.
module tb_factorial_engine;

  logic clk;
  logic resetn;

  factorial_engine_if #(.IN_W(4), .OUT_W(46)) a_if ();
  factorial_engine_if #(.IN_W(4), .OUT_W(16)) b_if ();

  factorial_engine #(.IN_W(4), .OUT_W(46)) u_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (a_if)
  );

  factorial_engine #(.IN_W(4), .OUT_W(16)) u_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] f_data(input int sel);
    return (sel != 0) ? 64'(b_if.out_data) : 64'(a_if.out_data);
  endfunction
  function automatic logic f_valid(input int sel);
    return (sel != 0) ? b_if.out_valid : a_if.out_valid;
  endfunction
  function automatic logic f_ovf(input int sel);
    return (sel != 0) ? b_if.out_ovf : a_if.out_ovf;
  endfunction
  function automatic logic f_ready(input int sel);
    return (sel != 0) ? b_if.in_ready : a_if.in_ready;
  endfunction
  function automatic logic f_busy(input int sel);
    return (sel != 0) ? b_if.out_busy : a_if.out_busy;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [3:0] n, input logic m);
    if (sel != 0) begin
      b_if.in_valid = v; b_if.in_data = n; b_if.in_mode = m;
    end else begin
      a_if.in_valid = v; a_if.in_data = n; a_if.in_mode = m;
    end
  endtask

  // Waits (bounded) for out_valid, then pops the scoreboard and compares.
  task automatic wait_result(input int sel, input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (f_valid(sel)) break;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_lat"}, 64'(lat), 64'(e.lat));
      check({tag, "_data"}, f_data(sel), e.data);
      check({tag, "_ovf"}, 64'(f_ovf(sel)), 64'(e.ovf));
    end
  endtask

  // Issues one request from a cycle where the engine is idle.
  task automatic do_req(input int sel, input string tag, input logic [3:0] n, input logic m,
                        input logic [63:0] exp_data, input logic exp_ovf, input int exp_lat,
                        input logic pulse_chk);
    exp_t e;
    check({tag, "_in_ready"}, 64'(f_ready(sel)), 64'd1);
    drive(sel, 1'b1, n, m);
    e.data = exp_data; e.ovf = exp_ovf; e.lat = exp_lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 4'd0, 1'b0);
    wait_result(sel, tag);
    if (pulse_chk) begin
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 64'(f_valid(sel)), 64'd0);
      check({tag, "_ready_after"}, 64'(f_ready(sel)), 64'd1);
    end
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 1'b0, 4'd0, 1'b0);
    drive(1, 1'b0, 4'd0, 1'b0);
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    #1;
    check("rst_in_ready", 64'(a_if.in_ready), 64'd1);
    check("rst_valid", 64'(a_if.out_valid), 64'd0);
    check("rst_busy", 64'(a_if.out_busy), 64'd0);
    check("rst_data", 64'(a_if.out_data), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Mode 0 on the wide instance.
    do_req(0, "f5", 4'd5, 1'b0, 64'd120, 1'b0, 5, 1'b1);
    do_req(0, "f15", 4'd15, 1'b0, 64'd1307674368000, 1'b0, 15, 1'b1);
    do_req(0, "f0", 4'd0, 1'b0, 64'd1, 1'b0, 1, 1'b1);
    do_req(0, "f1", 4'd1, 1'b0, 64'd1, 1'b0, 1, 1'b1);

    // Mode 1 (double factorial).
    do_req(0, "d7", 4'd7, 1'b1, 64'd105, 1'b0, 4, 1'b1);
    do_req(0, "d6", 4'd6, 1'b1, 64'd48, 1'b0, 4, 1'b1);
    do_req(0, "d1", 4'd1, 1'b1, 64'd1, 1'b0, 1, 1'b1);
    do_req(0, "d0", 4'd0, 1'b1, 64'd1, 1'b0, 1, 1'b1);
    do_req(0, "d15", 4'd15, 1'b1, 64'd2027025, 1'b0, 8, 1'b1);

    // Backpressure: result held for 10 cycles, new requests ignored meanwhile.
    a_if.out_ready = 1'b0;
    do_req(0, "bp", 4'd4, 1'b0, 64'd24, 1'b0, 4, 1'b0);
    drive(0, 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_data", f_data(0), 64'd24);
      check("bp_hold_valid", 64'(a_if.out_valid), 64'd1);
      check("bp_in_ready", 64'(a_if.in_ready), 64'd0);
    end
    a_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_drained", 64'(a_if.out_valid), 64'd0);
    check("bp_ready_next", 64'(a_if.in_ready), 64'd1);
    check("bp_not_taken", 64'(a_if.out_busy), 64'd0);
    check("bp_data_kept", f_data(0), 64'd24);
    drive(0, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    check("bp_still_idle", 64'(a_if.out_busy), 64'd0);

    // 16-bit result instance.
    do_req(1, "w8", 4'd8, 1'b0, 64'd40320, 1'b0, 8, 1'b1);
`ifdef FACTORIAL_ENGINE_OVF_EN
    do_req(1, "w9", 4'd9, 1'b0, 64'hFFFF, 1'b1, 7, 1'b1);
    do_req(1, "w8b", 4'd8, 1'b0, 64'd40320, 1'b0, 8, 1'b1);
`else
    do_req(1, "w9", 4'd9, 1'b0, 64'h8980, 1'b0, 9, 1'b1);
`endif

    // Reset mid-calculation abandons the request.
    drive(0, 1'b1, 4'd15, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 4'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy_pre", 64'(f_busy(0)), 64'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(a_if.out_valid), 64'd0);
    check("mid_rst_busy", 64'(a_if.out_busy), 64'd0);
    check("mid_rst_data", 64'(a_if.out_data), 64'd0);
    check("mid_rst_ovf", 64'(a_if.out_ovf), 64'd0);
    check("mid_rst_ready", 64'(a_if.in_ready), 64'd1);
    check("mid_rst_b_data", 64'(b_if.out_data), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 64'(a_if.out_valid), 64'd0);
    do_req(0, "r3", 4'd3, 1'b0, 64'd6, 1'b0, 3, 1'b1);

    check("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/factorial_engine.md
# factorial_engine

Parametrised iterative factorial unit with valid/ready handshakes on both sides. It computes n! or the double factorial n!! for one request at a time, one multiply per cycle. Output backpressure holds the result until it is accepted, and optional overflow detection saturates the result. It sits between a request producer and a result consumer in the arithmetic datapath.

## Interface
- IN_W, default 4: operand width. Legal range 1..8.
- OUT_W, default 46: result width. Legal range 2..64.
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_data  in  IN_W  operand n, unsigned.
- in_mode  in  1  0 = n!, 1 = n!! (step 2).
- in_valid  in  1  request present.
- in_ready  out  1  high exactly when state is IDLE.
- out_data  out  OUT_W  result.
- out_ovf  out  1  result overflowed OUT_W and is saturated.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_busy  out  1  high when state is not IDLE.

## Operation
- Reset values: out_data=0, out_ovf=0, out_valid=0, out_busy=0, state=IDLE. in_ready reads 1 while resetn is low.
- Reset mid-operation abandons the request immediately. No result is produced.
- Internal registers:
  - acc: OUT_W bits.
  - cnt: IN_W bits.
  - step: 1 or 2.
- States and transitions:
  - IDLE, accept when in_valid && in_ready:
    - cnt<=in_data, step<=in_mode?2:1, acc<=1.
    - out_ovf<=0, out_valid stays 0.
    - Go to CALC.
  - CALC, when cnt<=1:
    - out_data<=acc, out_valid<=1.
    - Go to DONE.
  - CALC, otherwise:
    - prod = acc*cnt, computed at OUT_W+IN_W bits.
    - acc<=prod[OUT_W-1:0]; cnt<=cnt-step.
    - With step 2, cnt passes through even values to 0, or odd values to 1. It never wraps.
  - CALC, overflow (see Configuration):
    - out_data<=all ones, out_ovf<=1, out_valid<=1.
    - Go to DONE directly.
  - DONE:
    - out_data, out_ovf and out_valid are held stable.
    - When out_valid && out_ready: out_valid<=0, go to IDLE.
- in_valid is ignored outside IDLE.
- A new request cannot be accepted in the same cycle the result is drained. in_ready rises the cycle after the drain.
- n=0 and n=1 return 1 in both modes.
- out_data keeps its last value after draining, until the next result is written.

## Timing
- Latency is counted in rising edges from the accept edge to the edge where out_valid rises.
  - Mode 0: max(n,1) edges.
  - Mode 1: floor(n/2)+1 edges.
- On overflow, latency equals the number of CALC cycles up to and including the overflowing multiply.
- Throughput with out_ready tied high: latency + 2 cycles per request (IDLE and DONE each take one cycle).
- out_valid is a one-cycle pulse when out_ready is high; otherwise it stays high until accepted.
- All outputs are registered except in_ready and out_busy, which decode the state register.

## Configuration
- Macro: FACTORIAL_ENGINE_OVF_EN.
- Defined:
  - Overflow means any nonzero bit in prod[OUT_W+IN_W-1:OUT_W].
  - On overflow the result saturates to all ones, out_ovf=1, and the calculation terminates early.
- Undefined:
  - No detection is performed; the result is the product modulo 2^OUT_W.
  - out_ovf is tied to 0.
  - Latency always follows the formulas in Timing.

## Test plan
- Reset:
  - Assert resetn low mid-CALC.
  - All outputs take their reset values; in_ready=1.
  - After release, a new request n=3 returns 6.
- Defaults, n=5, mode 0, out_ready=1:
  - out_data=120 with out_valid high exactly 5 edges after accept, for one cycle.
  - Then n=15 returns 1307674368000 after 15 edges.
  - Then n=0 returns 1 after 1 edge.
- Mode 1:
  - n=7 returns 105 after 4 edges.
  - n=6 returns 48 after 4 edges.
  - n=1 returns 1 after 1 edge.
- Backpressure, out_ready low for 10 cycles after out_valid rises:
  - out_data and out_valid stay stable; in_ready=0; an asserted in_valid is not accepted.
  - After the drain, in_ready returns 1 the next cycle.
- OUT_W=16, n=9, mode 0:
  - With the macro defined: out_data=0xFFFF and out_ovf=1 after 7 edges.
  - With the macro undefined: out_data=0x8980 (362880 mod 65536) and out_ovf=0 after 9 edges.
- OUT_W=16, n=8: returns 40320 with out_ovf=0 in both builds.
